// File: rtl/switch_display_ctrl_v2.sv
// Board-level switch front end: synchronises and debounces a switch array, tracks
// committed values with a Moore FSM, and drives packed active-low seven-segment digits.
module switch_display_ctrl_v2 #(
  parameter int unsigned NUM_SWITCHES    = 16,
  parameter int unsigned NUM_DIGITS      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned BOUNCE_LIMIT    = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SWITCHES-1:0] switch_array,
  input  logic [1:0]              mode,
  input  logic                    clear_err,
  output logic [NUM_DIGITS*7-1:0] seg,
  output logic [NUM_SWITCHES-1:0] committed,
  output logic                    commit_pulse,
  output logic [1:0]              state_o,
  output logic [7:0]              error_vector
);

  localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned BW  = $clog2(BOUNCE_LIMIT + 1) + 1;
  localparam int unsigned NIB = (NUM_SWITCHES + 3) / 4;
  localparam logic [CW-1:0] DTHR = CW'(DEBOUNCE_CYCLES - 1);
  // The change that opens a settle window counts toward the limit, so the
  // re-change count trips one short of BOUNCE_LIMIT.
  localparam logic [BW-1:0] BTHR = (BOUNCE_LIMIT == 0) ? '0 : BW'(BOUNCE_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SHOW   = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t                  state, state_n;
  logic [NUM_SWITCHES-1:0] sync1, sw_s;
  logic [NUM_SWITCHES-1:0] candidate, cand_n;
  logic [CW-1:0]           stable_cnt, stable_n;
  logic [BW-1:0]           bounce_cnt, bounce_n;
  logic [NUM_DIGITS*4-1:0] commit_cnt;
  logic                    do_commit, bounce_err, illegal, wrap;
  logic                    err0, err1, err2;
  logic [NUM_DIGITS*7-1:0] frame;
  logic [31:0]             comm_ext;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_n    = state;
    cand_n     = candidate;
    stable_n   = stable_cnt;
    bounce_n   = bounce_cnt;
    do_commit  = 1'b0;
    bounce_err = 1'b0;
    illegal    = 1'b0;
    case (state)
      ST_BLANK: begin
        if (sw_s == candidate) begin
          stable_n = stable_cnt + 1'b1;
          if (stable_cnt >= DTHR) begin
            do_commit = 1'b1;
            state_n   = ST_SHOW;
          end
        end else begin
          cand_n   = sw_s;
          stable_n = CW'(1);
        end
      end
      ST_SHOW: begin
        if (sw_s != committed) begin
          cand_n   = sw_s;
          stable_n = CW'(1);
          bounce_n = '0;
          state_n  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (sw_s == candidate) begin
          stable_n = stable_cnt + 1'b1;
          if (stable_cnt >= DTHR) begin
            do_commit = (candidate != committed);
            state_n   = ST_SHOW;
          end
        end else begin
          cand_n   = sw_s;
          stable_n = CW'(1);
          if (bounce_cnt >= BTHR) begin
            bounce_err = 1'b1;
            state_n    = ST_FAULT;
          end else begin
            bounce_n = bounce_cnt + 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (clear_err) begin
          stable_n = '0;
          state_n  = ST_BLANK;
        end
      end
      default: begin
        illegal = 1'b1;
        state_n = ST_BLANK;
      end
    endcase
  end

  assign wrap     = do_commit & (&commit_cnt);
  assign comm_ext = 32'(committed);

  always_comb begin
    frame = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      case (mode)
        2'd0: frame[7*i +: 7] = (i < NIB) ? hex_glyph(comm_ext[4*i +: 4]) : 7'h7F;
        2'd1: frame[7*i +: 7] = hex_glyph(commit_cnt[4*i +: 4]);
        2'd2: frame[7*i +: 7] = 7'h7F;
        default: frame[7*i +: 7] = 7'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1        <= '0;
      sw_s         <= '0;
      state        <= ST_BLANK;
      candidate    <= '0;
      stable_cnt   <= '0;
      bounce_cnt   <= '0;
      committed    <= '0;
      commit_cnt   <= '0;
      commit_pulse <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      err2         <= 1'b0;
      seg          <= '1;
    end else begin
      sync1        <= switch_array;
      sw_s         <= sync1;
      state        <= state_n;
      candidate    <= cand_n;
      stable_cnt   <= stable_n;
      bounce_cnt   <= bounce_n;
      commit_pulse <= do_commit;
      if (do_commit) begin
        committed  <= candidate;
        commit_cnt <= commit_cnt + 1'b1;
      end
      err0 <= illegal    | (err0 & ~clear_err);
      err1 <= bounce_err | (err1 & ~clear_err);
      err2 <= wrap       | (err2 & ~clear_err);
      case (state)
        ST_BLANK: seg <= '1;
        ST_FAULT: seg <= seg;
        default:  seg <= frame;
      endcase
    end
  end

  assign state_o      = state;
  assign error_vector = {4'b0000, (state == ST_FAULT), err2, err1, err0};

endmodule

// File: tb/tb_switch_display_ctrl_v2.sv
// Self-checking bench for switch_display_ctrl_v2: a default-size instance for the
// debounce/display behaviour and a small instance for commit-count wrap.
module tb_switch_display_ctrl_v2;

  localparam int NS = 16, ND = 8, DC = 16, BL = 7;
  localparam int NS2 = 4, ND2 = 2, DC2 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [1:0]  mode;
  logic        clr;
  logic [55:0] seg;
  logic [15:0] committed;
  logic        pulse;
  logic [1:0]  state;
  logic [7:0]  errv;

  logic [3:0]  sw2;
  logic [1:0]  mode2;
  logic        clr2;
  logic [13:0] seg2;
  logic [3:0]  comm2;
  logic        pulse2;
  logic [1:0]  state2;
  logic [7:0]  errv2;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_comm;
  int          m_cnt;
  logic [3:0]  m_comm2;
  int          m_cnt2;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  switch_display_ctrl_v2 #(
    .NUM_SWITCHES(NS), .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DC), .BOUNCE_LIMIT(BL)
  ) dut (
    .clk(clk), .rst(rst), .switch_array(sw), .mode(mode), .clear_err(clr),
    .seg(seg), .committed(committed), .commit_pulse(pulse), .state_o(state),
    .error_vector(errv)
  );

  switch_display_ctrl_v2 #(
    .NUM_SWITCHES(NS2), .NUM_DIGITS(ND2), .DEBOUNCE_CYCLES(DC2), .BOUNCE_LIMIT(BL)
  ) dut2 (
    .clk(clk), .rst(rst), .switch_array(sw2), .mode(mode2), .clear_err(clr2),
    .seg(seg2), .committed(comm2), .commit_pulse(pulse2), .state_o(state2),
    .error_vector(errv2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Expected display built directly from the digit/glyph rules.
  function automatic logic [55:0] exp_seg(input int nd, input int ns, input logic [1:0] md,
                                          input logic [31:0] val, input int cnt);
    logic [55:0] r;
    r = '1;
    for (int i = 0; i < nd; i++) begin
      case (md)
        2'd0: r[7*i +: 7] = (i < (ns + 3) / 4) ? glyph[int'((val >> (4*i)) & 32'hF)] : 7'h7F;
        2'd1: r[7*i +: 7] = glyph[(cnt >> (4*i)) & 15];
        2'd2: r[7*i +: 7] = 7'h7F;
        default: r[7*i +: 7] = 7'h00;
      endcase
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [55:0] e;
    rst = 1'b0; sw = 16'h1234; mode = 2'd0; clr = 1'b0;
    sw2 = 4'h5; mode2 = 2'd1; clr2 = 1'b0;
    #12;
    checks++; if (seg !== '1) begin errors++; $display("FAIL reset_seg: got %h expected all ones", seg); end
    checks++; if (committed !== 16'h0) begin errors++; $display("FAIL reset_committed: got %h expected 0", committed); end
    checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", pulse); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (errv !== 8'h00) begin errors++; $display("FAIL reset_err: got %h expected 00", errv); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 1; k <= DC + 1; k++) begin
      tick();
      checks++;
      if ({state, pulse, seg} !== {2'd0, 1'b0, {56{1'b1}}}) begin
        errors++;
        $display("FAIL reset_blank_hold edge %0d: state=%0d pulse=%b seg=%h expected BLANK/0/all ones", k, state, pulse, seg);
      end
    end
    tick();
    checks++; if ({pulse, committed, state} !== {1'b1, 16'h1234, 2'd2}) begin
      errors++; $display("FAIL reset_first_commit: pulse=%b committed=%h state=%0d expected 1/1234/2", pulse, committed, state);
    end
    m_comm = 16'h1234; m_cnt = 1;
    tick();
    e = exp_seg(ND, NS, mode, 32'(m_comm), m_cnt);
    checks++; if (seg !== e) begin errors++; $display("FAIL reset_first_frame: got %h expected %h", seg, e); end
    checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse_single: got %b expected 0", pulse); end
    m_comm2 = 4'h5; m_cnt2 = 1;
    e = exp_seg(ND2, NS2, mode2, 32'(m_comm2), m_cnt2);
    checks++; if ({comm2, seg2} !== {m_comm2, e[13:0]}) begin
      errors++; $display("FAIL reset_dut2: committed=%h seg=%h expected %h/%h", comm2, seg2, m_comm2, e[13:0]);
    end
  endtask

  task automatic test_change();
    logic [15:0] nv;
    logic [55:0] e;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) nv = 16'hABCD;
      else do nv = 16'($urandom); while (nv == m_comm);
      mode = (it == 0) ? 2'd0 : 2'($urandom_range(0, 1));
      sw = nv;
      for (int k = 1; k <= DC + 1; k++) begin
        tick();
        if (k == 3) begin
          checks++; if (state !== 2'd1) begin errors++; $display("FAIL change_settle_entry: got %0d expected 1", state); end
        end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL change_early_pulse edge %0d: got %b expected 0", k, pulse); end
      end
      tick();
      checks++; if ({pulse, committed} !== {1'b1, nv}) begin
        errors++; $display("FAIL change_commit: pulse=%b committed=%h expected 1/%h", pulse, committed, nv);
      end
      m_comm = nv; m_cnt++;
      tick();
      e = exp_seg(ND, NS, mode, 32'(m_comm), m_cnt);
      checks++; if (seg !== e) begin errors++; $display("FAIL change_frame: got %h expected %h", seg, e); end
    end
  endtask

  task automatic test_modes();
    logic [55:0] e;
    for (int k = 0; k < 8; k++) begin
      mode = (k < 4) ? 2'(k) : 2'($urandom_range(0, 3));
      tick();
      e = exp_seg(ND, NS, mode, 32'(m_comm), m_cnt);
      checks++; if (seg !== e) begin errors++; $display("FAIL mode_%0d: got %h expected %h", mode, seg, e); end
    end
    mode = 2'd0;
    tick();
  endtask

  task automatic test_glitch();
    logic [15:0] v;
    logic [55:0] e;
    v = m_comm;
    sw = v ^ 16'h0001;
    tick();
    tick();
    sw = v;
    for (int k = 0; k < DC + 8; k++) begin
      tick();
      checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL glitch_pulse: got %b expected 0", pulse); end
    end
    checks++; if ({state, committed} !== {2'd2, v}) begin
      errors++; $display("FAIL glitch_return: state=%0d committed=%h expected 2/%h", state, committed, v);
    end
    mode = 2'd1;
    tick();
    e = exp_seg(ND, NS, mode, 32'(m_comm), m_cnt);
    checks++; if (seg !== e) begin errors++; $display("FAIL glitch_count: got %h expected %h", seg, e); end
    mode = 2'd0;
    tick();
  endtask

  task automatic test_bounce();
    logic [15:0] v, cur;
    logic [55:0] frame;
    logic [1:0]  est;
    int          changes, fault_edge;
    logic        found;
    v = m_comm; cur = v; changes = 0;
    fault_edge = 3 * (BL + 1);
    frame = exp_seg(ND, NS, 2'd0, 32'(m_comm), m_cnt);
    for (int k = 0; k <= 30; k++) begin
      if (k % 3 == 0 && changes < 9) begin
        cur = cur ^ 16'h0001; sw = cur; changes++;
      end
      tick();
      est = (k + 1 < 3) ? 2'd2 : (k + 1 < fault_edge) ? 2'd1 : 2'd3;
      checks++; if (state !== est) begin errors++; $display("FAIL bounce_state edge %0d: got %0d expected %0d", k + 1, state, est); end
      if (k + 1 == fault_edge) begin
        checks++; if (errv !== 8'h0A) begin errors++; $display("FAIL bounce_err_set: got %h expected 0a", errv); end
      end
    end
    checks++; if ({committed, seg} !== {v, frame}) begin
      errors++; $display("FAIL bounce_frozen: committed=%h seg=%h expected %h/%h", committed, seg, v, frame);
    end
    mode = 2'd3;
    tick();
    tick();
    checks++; if (seg !== frame) begin errors++; $display("FAIL fault_display_hold: got %h expected %h", seg, frame); end
    checks++; if (errv !== 8'h0A) begin errors++; $display("FAIL fault_err_sticky: got %h expected 0a", errv); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if ({state, errv} !== {2'd0, 8'h00}) begin
      errors++; $display("FAIL clear_to_blank: state=%0d err=%h expected 0/00", state, errv);
    end
    mode = 2'd0;
    tick();
    checks++; if (seg !== '1) begin errors++; $display("FAIL clear_blank_seg: got %h expected all ones", seg); end
    found = 1'b0;
    for (int k = 0; k < DC + 4 && !found; k++) begin
      tick();
      if (pulse === 1'b1) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL recommit_timeout: pulse=%b expected 1 within %0d edges", found, DC + 4); end
    checks++; if (committed !== cur) begin errors++; $display("FAIL recommit_value: got %h expected %h", committed, cur); end
    m_comm = cur; m_cnt++;
    tick();
    frame = exp_seg(ND, NS, mode, 32'(m_comm), m_cnt);
    checks++; if (seg !== frame) begin errors++; $display("FAIL recommit_frame: got %h expected %h", seg, frame); end
  endtask

  task automatic commit2(input logic clr_on_commit);
    logic [3:0] nv;
    do nv = 4'($urandom); while (nv == m_comm2);
    sw2 = nv;
    for (int k = 1; k <= DC2 + 1; k++) tick();
    checks++; if (pulse2 !== 1'b0) begin errors++; $display("FAIL wrap_early_pulse: got %b expected 0", pulse2); end
    clr2 = clr_on_commit;
    tick();
    clr2 = 1'b0;
    checks++; if ({pulse2, comm2} !== {1'b1, nv}) begin
      errors++; $display("FAIL wrap_commit: pulse=%b committed=%h expected 1/%h", pulse2, comm2, nv);
    end
    m_comm2 = nv;
    m_cnt2 = (m_cnt2 + 1) % 256;
  endtask

  task automatic test_wrap();
    logic [55:0] e;
    while (m_cnt2 != 255) commit2(1'b0);
    checks++; if (errv2 !== 8'h00) begin errors++; $display("FAIL wrap_pre: got %h expected 00", errv2); end
    commit2(1'b0);
    checks++; if (errv2 !== 8'h04) begin errors++; $display("FAIL wrap_err_set: got %h expected 04", errv2); end
    tick();
    e = exp_seg(ND2, NS2, mode2, 32'(m_comm2), m_cnt2);
    checks++; if (seg2 !== e[13:0]) begin errors++; $display("FAIL wrap_count_display: got %h expected %h", seg2, e[13:0]); end
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    checks++; if (errv2 !== 8'h00) begin errors++; $display("FAIL wrap_clear: got %h expected 00", errv2); end
    while (m_cnt2 != 255) commit2(1'b0);
    commit2(1'b1);
    checks++; if (errv2 !== 8'h04) begin errors++; $display("FAIL wrap_set_beats_clear: got %h expected 04", errv2); end
    tick();
    checks++; if (errv2 !== 8'h04) begin errors++; $display("FAIL wrap_sticky: got %h expected 04", errv2); end
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    checks++; if (errv2 !== 8'h00) begin errors++; $display("FAIL wrap_clear2: got %h expected 00", errv2); end
  endtask

  task automatic test_reset_mid_settle();
    logic [15:0] nv;
    do nv = 16'($urandom); while (nv == m_comm);
    sw = nv;
    for (int k = 0; k < 6; k++) tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL midreset_in_settle: got %0d expected 1", state); end
    #3;
    rst = 1'b0;
    #1;
    checks++; if ({seg, committed, pulse, state, errv} !== {{56{1'b1}}, 16'h0, 1'b0, 2'd0, 8'h00}) begin
      errors++; $display("FAIL midreset_outputs: seg=%h committed=%h pulse=%b state=%0d err=%h expected reset values",
                         seg, committed, pulse, state, errv);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    m_comm = '0; m_cnt = 0;
    for (int k = 1; k <= DC + 1; k++) begin
      tick();
      checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL midreset_no_commit edge %0d: got %b expected 0", k, pulse); end
    end
    tick();
    checks++; if ({pulse, committed} !== {1'b1, nv}) begin
      errors++; $display("FAIL midreset_recommit: pulse=%b committed=%h expected 1/%h", pulse, committed, nv);
    end
  endtask

  initial begin
    test_reset();
    test_change();
    test_modes();
    test_glitch();
    test_bounce();
    test_wrap();
    test_reset_mid_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
